// File: rtl/wrapper_shared_pkg.sv
// Shared definitions for the SPI wrapper: master FSM states, frame commands
// and the default payload width.
package wrapper_shared_pkg;

  localparam int ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CMD,
    SHIFT,
    WAIT,
    RECV,
    DESELECT
  } MST_STATE_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mst_shifter.sv
// Frame datapath for spi_master: parallel-load MSB-first transmit register,
// serial receive register and a shared down-counting bit counter.
module spi_mst_shifter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ADDR_SIZE+1:0] frame,
  input  logic                 shift_out,
  input  logic                 shift_in,
  input  logic                 miso,
  input  logic                 cnt_load,
  input  logic [3:0]           cnt_init,
  input  logic                 cnt_dec,
  output logic                 tx_msb,
  output logic [ADDR_SIZE-1:0] rx_next,
  output logic                 cnt_zero
);

  logic [ADDR_SIZE+1:0] tx;
  logic [ADDR_SIZE-1:0] rx;
  logic [3:0]           cnt;

  assign tx_msb   = tx[ADDR_SIZE+1];
  assign rx_next  = {rx[ADDR_SIZE-2:0], miso};
  assign cnt_zero = (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx  <= '0;
      rx  <= '0;
      cnt <= '0;
    end else begin
      if (load)
        tx <= frame;
      else if (shift_out)
        tx <= {tx[ADDR_SIZE:0], 1'b0};
      if (shift_in)
        rx <= rx_next;
      if (cnt_load)
        cnt <= cnt_init;
      else if (cnt_dec)
        cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: serialises {cmd,payload} frames MSB first and collects the read
// reply for rd-data commands. Define SPI_MST_SEQ_CHECK_EN for command-order checking.
//
// state    | meaning
// IDLE     | SS_n high, waiting for start
// SELECT   | SS_n low, MOSI 0
// CMD      | MOSI = frame MSB (slave decodes write/read)
// SHIFT    | MOSI = frame bits MSB first, 10 cycles
// WAIT     | slave/memory latency before reply, MISO_WAIT cycles
// RECV     | sample MISO into the reply byte, 8 cycles
// DESELECT | SS_n high, done (and rd_valid for rd-data)
module spi_master #(
  parameter int ADDR_SIZE = wrapper_shared_pkg::ADDR_SIZE,
  parameter int MISO_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [ADDR_SIZE-1:0] payload,
  input  logic                 MISO,
  output logic                 SS_n,
  output logic                 MOSI,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 err
);
  import wrapper_shared_pkg::*;

  localparam int FW     = ADDR_SIZE + 2;
  localparam int WAIT_W = (MISO_WAIT > 0) ? $clog2(MISO_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'((MISO_WAIT > 0) ? MISO_WAIT - 1 : 0);

  MST_STATE_e state, state_nxt;
  logic [1:0]           cmd_q;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 load, shift_out, shift_in, cnt_load, cnt_dec;
  logic [3:0]           cnt_init;
  logic                 wait_load, wait_dec, mosi_nxt, capture;
  logic                 tx_msb, cnt_zero, seq_bad;
  logic [ADDR_SIZE-1:0] rx_next;

  spi_mst_shifter #(.ADDR_SIZE(ADDR_SIZE)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .frame    ({cmd, payload}),
    .shift_out(shift_out),
    .shift_in (shift_in),
    .miso     (MISO),
    .cnt_load (cnt_load),
    .cnt_init (cnt_init),
    .cnt_dec  (cnt_dec),
    .tx_msb   (tx_msb),
    .rx_next  (rx_next),
    .cnt_zero (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_out = 1'b0;
    shift_in  = 1'b0;
    cnt_load  = 1'b0;
    cnt_init  = '0;
    cnt_dec   = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    mosi_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !seq_bad) begin
          load      = 1'b1;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        mosi_nxt  = tx_msb;
        state_nxt = CMD;
      end
      CMD: begin
        mosi_nxt  = tx_msb;
        shift_out = 1'b1;
        cnt_load  = 1'b1;
        cnt_init  = 4'(FW - 1);
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!cnt_zero) begin
          mosi_nxt  = tx_msb;
          shift_out = 1'b1;
          cnt_dec   = 1'b1;
        end else if (cmd_q != CMD_RD_DATA) begin
          state_nxt = DESELECT;
        end else if (MISO_WAIT > 0) begin
          wait_load = 1'b1;
          state_nxt = WAIT;
        end else begin
          cnt_load  = 1'b1;
          cnt_init  = 4'(ADDR_SIZE - 1);
          state_nxt = RECV;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          cnt_load  = 1'b1;
          cnt_init  = 4'(ADDR_SIZE - 1);
          state_nxt = RECV;
        end else begin
          wait_dec = 1'b1;
        end
      end
      RECV: begin
        shift_in = 1'b1;
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = DESELECT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DESELECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      wait_cnt <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      SS_n     <= (state_nxt == IDLE) || (state_nxt == DESELECT);
      MOSI     <= mosi_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DESELECT);
      rd_valid <= capture;
      if (load)
        cmd_q <= cmd;
      if (capture)
        rd_data <= rx_next;
      if (wait_load)
        wait_cnt <= WAIT_LD;
      else if (wait_dec)
        wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

`ifdef SPI_MST_SEQ_CHECK_EN
  logic rd_pend;

  assign seq_bad = ((cmd == CMD_RD_DATA) && !rd_pend) || ((cmd == CMD_RD_ADDR) && rd_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && seq_bad;
      if (load && (cmd == CMD_RD_ADDR))
        rd_pend <= 1'b1;
      else if (capture)
        rd_pend <= 1'b0;
    end
  end
`else
  assign seq_bad = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table vectors, corner-case sequences and
// randomized write/read pairs against a behavioural slave and reference memory.
module tb_spi_master;

  localparam int W    = 2;
  localparam int LOGN = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] payload = 8'h00;
  logic       MISO = 1'b0;
  logic       SS_n, MOSI, busy, done, rd_valid, err;
  logic [7:0] rd_data;

  spi_master #(.ADDR_SIZE(8), .MISO_WAIT(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .payload(payload),
    .MISO(MISO), .SS_n(SS_n), .MOSI(MOSI), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // per-edge stimulus (driven before edge k) and logged outputs (after edge k)
  logic       start_s [LOGN];
  logic [1:0] cmd_s   [LOGN];
  logic [7:0] pay_s   [LOGN];
  logic       miso_s  [LOGN];
  logic       log_ss  [LOGN];
  logic       log_mosi[LOGN];
  logic       log_done[LOGN];
  logic       log_busy[LOGN];
  logic       log_rdv [LOGN];
  logic       log_err [LOGN];
  logic [7:0] log_rd  [LOGN];

  // slave model (fed by observed MOSI) and host-side reference model
  logic [7:0] s_mem[256];
  logic [7:0] r_mem[256];
  logic [7:0] s_wptr = 0, s_rptr = 0, r_wptr = 0, r_rptr = 0;

  typedef struct {
    logic [1:0] c;
    logic [7:0] p;
    int         len;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int frame_len(input logic [1:0] c);
    return (c == 2'b11) ? 13 + W + 8 : 13;
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < LOGN; k++) begin
      start_s[k] = 1'b0;
      cmd_s[k]   = 2'b00;
      pay_s[k]   = 8'h00;
      miso_s[k]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sched_frame(input int s, input logic [1:0] c, input logic [7:0] p);
    logic [7:0] b;
    start_s[s] = 1'b1;
    cmd_s[s]   = c;
    pay_s[s]   = p;
    if (c == 2'b11) begin
      b = s_mem[s_rptr];
      for (int j = 0; j < 8; j++) miso_s[s + 13 + W + j] = b[7-j];
    end
  endtask

  // called at a negedge; returns at the negedge after the last edge
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      start   = start_s[k];
      cmd     = cmd_s[k];
      payload = pay_s[k];
      MISO    = miso_s[k];
      @(posedge clk);
      @(negedge clk);
      log_ss[k]   = SS_n;
      log_mosi[k] = MOSI;
      log_done[k] = done;
      log_busy[k] = busy;
      log_rdv[k]  = rd_valid;
      log_err[k]  = err;
      log_rd[k]   = rd_data;
    end
    start = 1'b0;
  endtask

  task automatic slave_decode(input int s);
    logic [9:0] f;
    for (int i = 0; i < 10; i++) f[9-i] = log_mosi[s + 2 + i];
    case (f[9:8])
      2'b00: s_wptr = f[7:0];
      2'b01: s_mem[s_wptr] = f[7:0];
      2'b10: s_rptr = f[7:0];
      default: ;
    endcase
  endtask

  task automatic ref_apply(input logic [1:0] c, input logic [7:0] p);
    case (c)
      2'b00: r_wptr = p;
      2'b01: r_mem[r_wptr] = p;
      2'b10: r_rptr = p;
      default: ;
    endcase
  endtask

  task automatic check_frame(input string tag, input int s, input logic [1:0] c,
                             input logic [7:0] p, input int len, input logic [7:0] rd);
    logic [9:0]  f;
    logic [11:0] act_m, exp_m;
    int low, dk, nd, nrv;
    f = {c, p};
    exp_m = {1'b0, f[9], f};
    for (int i = 0; i < 12; i++) act_m[11-i] = log_mosi[s + i];
    check({tag, "_mosi"}, 32'(act_m), 32'(exp_m));
    low = 0;
    while ((s + low < LOGN) && (log_ss[s + low] == 1'b0)) low++;
    check({tag, "_ss_low"}, 32'(low), 32'(len - 1));
    nd = 0; dk = -1; nrv = 0;
    for (int k = s; k <= s + len; k++) begin
      if (log_done[k]) begin
        nd++;
        if (dk < 0) dk = k;
      end
      if (log_rdv[k]) nrv++;
    end
    check({tag, "_done_at"}, 32'(dk), 32'(s + len - 1));
    check({tag, "_done_cnt"}, 32'(nd), 32'd1);
    check({tag, "_busy_end"}, 32'({log_busy[s + len - 1], log_busy[s + len]}), 32'b10);
    if (c == 2'b11) begin
      check({tag, "_rd_valid"}, 32'({log_rdv[s + len - 2], log_rdv[s + len - 1], log_rdv[s + len]}), 32'b010);
      check({tag, "_rd_data"}, 32'(log_rd[s + len - 1]), 32'(rd));
    end else begin
      check({tag, "_no_rd_valid"}, 32'(nrv), 32'd0);
    end
  endtask

  task automatic one_frame(input string tag, input int gap, input logic [1:0] c,
                           input logic [7:0] p, input int len, input logic [7:0] rd);
    clear_sched();
    sched_frame(gap, c, p);
    run(gap + len + 1);
    check_frame(tag, gap, c, p, len, rd);
    slave_decode(gap);
    ref_apply(c, p);
  endtask

  initial begin
    int nd, nlow;
    logic [7:0] a, d, exp_rd;
    logic [7:0] v;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      s_mem[i] = v;
      r_mem[i] = v;
    end
    s_mem[8'h3C] = 8'h5E;
    r_mem[8'h3C] = 8'h5E;

    tbl[0] = '{2'b00, 8'hA5, 13, 8'h00};
    tbl[1] = '{2'b01, 8'h77, 13, 8'h00};
    tbl[2] = '{2'b10, 8'h3C, 13, 8'h00};
    tbl[3] = '{2'b11, 8'h00, 23, 8'h5E};
    tbl[4] = '{2'b10, 8'hA5, 13, 8'h00};
    tbl[5] = '{2'b11, 8'hFF, 23, 8'h77};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ss_mosi", 32'({SS_n, MOSI}), 32'b10);
    check("reset_busy_done", 32'({busy, done, rd_valid, err}), 32'b0000);
    check("reset_rd_data", 32'(rd_data), 32'h00);

    // rd-data straight out of reset
`ifdef SPI_MST_SEQ_CHECK_EN
    clear_sched();
    start_s[0] = 1'b1; cmd_s[0] = 2'b11; pay_s[0] = 8'h12;
    run(4);
    check("seq_err_pulse", 32'({log_err[0], log_err[1]}), 32'b10);
    check("seq_ss_idle", 32'({log_ss[0], log_ss[1], log_ss[2], log_ss[3]}), 32'b1111);
    check("seq_busy_idle", 32'({log_busy[0], log_busy[1], log_busy[2], log_busy[3]}), 32'b0000);
`else
    one_frame("rd_from_reset", 0, 2'b11, 8'h12, frame_len(2'b11), r_mem[r_rptr]);
`endif

    for (int i = 0; i < 6; i++)
      one_frame($sformatf("tbl%0d", i), 0, tbl[i].c, tbl[i].p, tbl[i].len, tbl[i].rd);

    // start pulsed mid-frame must be ignored
    clear_sched();
    sched_frame(0, 2'b00, 8'hC3);
    start_s[5] = 1'b1; cmd_s[5] = 2'b01; pay_s[5] = 8'h99;
    run(18);
    check_frame("ign", 0, 2'b00, 8'hC3, 13, 8'h00);
    nd = 0; nlow = 0;
    for (int k = 0; k < 18; k++) if (log_done[k]) nd++;
    for (int k = 12; k < 18; k++) if (!log_ss[k]) nlow++;
    check("ign_done_total", 32'(nd), 32'd1);
    check("ign_no_second", 32'(nlow), 32'd0);
    slave_decode(0);
    ref_apply(2'b00, 8'hC3);

    // reset at e7 of a rd-data frame
    one_frame("pre_rst", 0, 2'b10, 8'h44, 13, 8'h00);
    clear_sched();
    sched_frame(0, 2'b11, 8'h00);
    run(7);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ss_busy", 32'({SS_n, busy}), 32'b10);
    check("rst_mid_pulses", 32'({done, rd_valid, err}), 32'b000);
    check("rst_mid_rd_data", 32'(rd_data), 32'h00);
    nd = 0;
    for (int k = 0; k < 7; k++) if (log_done[k] || log_rdv[k]) nd++;
    check("rst_mid_no_done", 32'(nd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    one_frame("post_rst", 0, 2'b00, 8'h5A, 13, 8'h00);

    // back-to-back with start held high
    clear_sched();
    for (int k = 0; k <= 14; k++) begin
      start_s[k] = 1'b1;
      cmd_s[k]   = (k == 0) ? 2'b00 : 2'b01;
      pay_s[k]   = (k == 0) ? 8'h10 : 8'hFF;
    end
    run(28);
    check_frame("b2b_a", 0, 2'b00, 8'h10, 13, 8'h00);
    check_frame("b2b_b", 14, 2'b01, 8'hFF, 13, 8'h00);
    check("b2b_ss_gap", 32'({log_ss[11], log_ss[12], log_ss[13], log_ss[14]}), 32'b0110);
    slave_decode(0);
    slave_decode(14);
    ref_apply(2'b00, 8'h10);
    ref_apply(2'b01, 8'hFF);

    // randomized write/read pairs
    for (int it = 0; it < 30; it++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        one_frame("rnd_wa", $urandom_range(0, 3), 2'b00, a, frame_len(2'b00), 8'h00);
        one_frame("rnd_wd", $urandom_range(0, 3), 2'b01, d, frame_len(2'b01), 8'h00);
      end else begin
        one_frame("rnd_ra", $urandom_range(0, 3), 2'b10, a, frame_len(2'b10), 8'h00);
        exp_rd = r_mem[r_rptr];
        one_frame("rnd_rd", $urandom_range(0, 3), 2'b11, d, frame_len(2'b11), exp_rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
